bp_fe_fetch_buffer: RTL and testbench
=====================================

Name: bp_fe_fetch_buffer

Overview:
- Small in-order FIFO directly downstream of the FE realigner.
- Accepts reconstructed instructions (PC, 32-bit word, partial flag) under a valid/yumi handshake.
- Presents them to the FE queue packer under a valid/ready handshake.
- Decouples realigner output from backend back-pressure; squashed atomically on redirect.

Parameters:
- vaddr_width_p, 39, virtual address width of instruction PCs.
- instr_width_p, 32, instruction word width.
- els_p, 4, number of entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- flush_i  in  1  redirect/poison; discards all entries.
- fetch_instr_v_i  in  1  realigner has a valid instruction.
- fetch_instr_pc_i  in  vaddr_width_p  PC of incoming instruction.
- fetch_instr_i  in  instr_width_p  incoming instruction word.
- fetch_partial_i  in  1  instruction was reconstructed from two halves.
- fetch_instr_yumi_o  out  1  buffer consumes the incoming instruction this cycle.
- instr_v_o  out  1  head entry valid.
- instr_pc_o  out  vaddr_width_p  head PC.
- instr_o  out  instr_width_p  head instruction.
- instr_partial_o  out  1  head partial flag.
- instr_ready_and_i  in  1  consumer accepts head when instr_v_o=1.
- count_o  out  $clog2(els_p+1)  current occupancy.
- full_o  out  1  occupancy == els_p.

Behaviour:
- Reset (reset_n_i=0 at clock edge):
  - rd_ptr, wr_ptr and count cleared to 0.
  - Next cycle: instr_v_o=0, full_o=0, count_o=0, fetch_instr_yumi_o=0 unless fetch_instr_v_i=1.
  - Entry storage need not be reset; data outputs are don't-care while instr_v_o=0.
  - Reset dominates flush, enqueue and dequeue.
- Enqueue: fetch_instr_yumi_o = fetch_instr_v_i & ~full_o & ~flush_i & reset_n_i.
  - Combinational from registered full_o; there is no path from instr_ready_and_i to yumi.
  - When yumi=1, {pc, instr, partial} are written at wr_ptr and wr_ptr advances mod els_p.
- Dequeue: deq = instr_v_o & instr_ready_and_i.
  - instr_v_o = (count != 0) & ~flush_i.
  - Head fields are driven from entry rd_ptr; rd_ptr advances mod els_p on deq.
- Latency: an instruction enqueued in cycle N is visible at the head in cycle N+1 at the earliest. There is no same-cycle bypass.
- count update:
  - +1 on enq only, -1 on deq only, unchanged when both or neither.
  - Never exceeds els_p and never underflows.
- Full with simultaneous deq: enqueue is still refused that cycle; full_o drops the next cycle.
- Empty: instr_v_o=0. A same-cycle input is not forwarded.
- Flush (flush_i=1):
  - Same cycle: yumi=0 and instr_v_o=0, so no enqueue and no dequeue happen.
  - Next edge: rd_ptr=wr_ptr=count=0.
  - Flush asserted for multiple cycles keeps the buffer empty.
  - The first enqueue is possible in the cycle after flush deasserts.
- Pointer wrap: pointers are $clog2(els_p) bits and wrap naturally. Ordering is strictly FIFO across wrap.
- Entry fields are stored unmodified; the buffer never inspects the instruction or the partial flag.
- Assertions (simulation only):
  - fetch_instr_pc_i is held while fetch_instr_v_i=1 and yumi=0.
  - count_o <= els_p at all times.

Test Plan:
- Reset then single pass-through: enqueue pc=0x80000000, instr=0x00000013, partial=0.
  - yumi=1 in cycle 0.
  - instr_v_o=1 in cycle 1 with identical fields.
  - ready=1 gives count_o=0 in cycle 2.
- Fill with els_p=4 and ready=0: enqueue pcs 0x1000, 0x1004, 0x1008, 0x100C.
  - full_o=1 and count_o=4.
  - A fifth valid input sees yumi=0.
  - With ready=1 and v=1 together, that cycle has no enqueue; next cycle full_o=0 and yumi=1.
- Wrap and order: stream 10 instructions with ready toggling every other cycle.
  - Output PCs are exactly in input order.
  - The partial flag pattern 0,1,0,... is preserved per entry.
- Flush mid-stream: count_o=3, then flush_i=1 for 1 cycle with fetch_instr_v_i=1.
  - That cycle: yumi=0 and instr_v_o=0.
  - Next cycle: count_o=0.
  - New pc=0x2000 is enqueued and emerges first.
- Reset mid-operation: count_o=2, then reset_n_i=0 for 1 cycle.
  - Next cycle count_o=0 and instr_v_o=0; old entries never appear.
- Simultaneous enq/deq at count_o=1 for 8 cycles: count_o stays 1 and output lags input by exactly one entry.

Source files
------------

// File: rtl/bp_fe_fetch_buffer.sv
// Purpose: in-order instruction FIFO between the FE realigner and the FE queue packer.
// Latency: one cycle from enqueue to head visibility; no same-cycle bypass.
// Backpressure: yumi withheld while full or flushing; full drops one cycle after a dequeue.
module bp_fe_fetch_buffer #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int els_p         = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         flush_i,

    input  logic                         fetch_instr_v_i,
    input  logic [vaddr_width_p-1:0]     fetch_instr_pc_i,
    input  logic [instr_width_p-1:0]     fetch_instr_i,
    input  logic                         fetch_partial_i,
    output logic                         fetch_instr_yumi_o,

    output logic                         instr_v_o,
    output logic [vaddr_width_p-1:0]     instr_pc_o,
    output logic [instr_width_p-1:0]     instr_o,
    output logic                         instr_partial_o,
    input  logic                         instr_ready_and_i,

    output logic [$clog2(els_p+1)-1:0]   count_o,
    output logic                         full_o
);

    localparam int PTR_W = $clog2(els_p);
    localparam int CNT_W = $clog2(els_p+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(els_p);

    // One stored instruction; fields are kept exactly as the realigner produced them.
    typedef struct packed {
        logic [vaddr_width_p-1:0] pc;
        logic [instr_width_p-1:0] instr;
        logic                     partial;
    } entry_t;

    entry_t            mem [els_p];
    entry_t            wr_dat;
    entry_t            rd_dat;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              enq_vld;
    logic              deq_vld;

    // Handshakes: enqueue depends only on registered occupancy, never on the consumer.
    always_comb begin
        full_o             = (count == FULL_CNT);
        fetch_instr_yumi_o = fetch_instr_v_i & ~full_o & ~flush_i & reset_n_i;
        instr_v_o          = (count != '0) & ~flush_i;
        enq_vld            = fetch_instr_yumi_o;
        deq_vld            = instr_v_o & instr_ready_and_i;
        count_o            = count;
    end

    // Pack incoming fields and unpack the head entry.
    always_comb begin
        wr_dat.pc       = fetch_instr_pc_i;
        wr_dat.instr    = fetch_instr_i;
        wr_dat.partial  = fetch_partial_i;
        rd_dat          = mem[rd_ptr];
        instr_pc_o      = rd_dat.pc;
        instr_o         = rd_dat.instr;
        instr_partial_o = rd_dat.partial;
    end

    // Pointer and occupancy state; reset beats flush, flush beats enqueue/dequeue.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_vld) wr_ptr <= wr_ptr + 1'b1;
            if (deq_vld) rd_ptr <= rd_ptr + 1'b1;
            case ({enq_vld, deq_vld})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage is never reset; contents are only observed when instr_v_o is high.
    always_ff @(posedge clk_i) begin
        if (enq_vld) mem[wr_ptr] <= wr_dat;
    end

    // A stalled producer must keep presenting the same PC until it is consumed.
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (fetch_instr_v_i && !fetch_instr_yumi_o && !flush_i)
            |=> (!fetch_instr_v_i || $stable(fetch_instr_pc_i)));

    // Occupancy can never exceed the entry count.
    assert property (@(posedge clk_i) disable iff (!reset_n_i) (count <= FULL_CNT));

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Purpose: directed stimulus with a scoreboard queue and an independent output monitor.
// Latency: expects head visibility one cycle after enqueue.
// Backpressure: drives instr_ready_and_i patterns and checks yumi/full/count directly.
module tb_bp_fe_fetch_buffer;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        flush_i;
    logic        fetch_instr_v_i;
    logic [38:0] fetch_instr_pc_i;
    logic [31:0] fetch_instr_i;
    logic        fetch_partial_i;
    logic        fetch_instr_yumi_o;
    logic        instr_v_o;
    logic [38:0] instr_pc_o;
    logic [31:0] instr_o;
    logic        instr_partial_o;
    logic        instr_ready_and_i;
    logic [2:0]  count_o;
    logic        full_o;

    typedef struct packed {
        logic [38:0] pc;
        logic [31:0] instr;
        logic        partial;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    bp_fe_fetch_buffer #(.vaddr_width_p(39), .instr_width_p(32), .els_p(4)) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .flush_i            (flush_i),
        .fetch_instr_v_i    (fetch_instr_v_i),
        .fetch_instr_pc_i   (fetch_instr_pc_i),
        .fetch_instr_i      (fetch_instr_i),
        .fetch_partial_i    (fetch_partial_i),
        .fetch_instr_yumi_o (fetch_instr_yumi_o),
        .instr_v_o          (instr_v_o),
        .instr_pc_o         (instr_pc_o),
        .instr_o            (instr_o),
        .instr_partial_o    (instr_partial_o),
        .instr_ready_and_i  (instr_ready_and_i),
        .count_o            (count_o),
        .full_o             (full_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [38:0] pc, input logic [31:0] ins,
                         input logic p, input logic rdy);
        fetch_instr_v_i   = v;
        fetch_instr_pc_i  = pc;
        fetch_instr_i     = ins;
        fetch_partial_i   = p;
        instr_ready_and_i = rdy;
    endtask

    task automatic push_exp(input logic [38:0] pc, input logic [31:0] ins, input logic p);
        exp_t e;
        e.pc      = pc;
        e.instr   = ins;
        e.partial = p;
        sb.push_back(e);
    endtask

    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every accepted head entry must match the oldest expected entry.
    always @(negedge clk_i) begin
        if (reset_n_i === 1'b1 && instr_v_o === 1'b1 && instr_ready_and_i === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_out pc=0x%0h instr=0x%0h expected=none",
                         instr_pc_o, instr_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (instr_pc_o !== e.pc || instr_o !== e.instr || instr_partial_o !== e.partial) begin
                    failures++;
                    $display("FAIL sb_out actual=%0h/%0h/%0b expected=%0h/%0h/%0b",
                             instr_pc_o, instr_o, instr_partial_o, e.pc, e.instr, e.partial);
                end
            end
        end
    end

    initial begin
        int sent;
        int cyc;
        int model_cnt;
        logic exp_enq;
        logic exp_deq;

        reset_n_i = 1'b0;
        flush_i   = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        next_cyc();
        next_cyc();
        reset_n_i = 1'b1;

        // Reset state
        @(negedge clk_i);
        chk("rst_count", 64'(count_o), 0);
        chk("rst_v", 64'(instr_v_o), 0);
        chk("rst_full", 64'(full_o), 0);
        chk("rst_yumi", 64'(fetch_instr_yumi_o), 0);
        next_cyc();

        // Single pass-through
        drive(1'b1, 39'h80000000, 32'h00000013, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("pt_yumi_c0", 64'(fetch_instr_yumi_o), 1);
        chk("pt_v_c0", 64'(instr_v_o), 0);
        push_exp(39'h80000000, 32'h00000013, 1'b0);
        next_cyc();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        @(negedge clk_i);
        chk("pt_v_c1", 64'(instr_v_o), 1);
        next_cyc();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("pt_count_c2", 64'(count_o), 0);
        next_cyc();

        // Fill to full with ready low
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 39'h1000 + 39'(4*i), 32'hB0000000 + 32'(i), 1'(i & 1), 1'b0);
            @(negedge clk_i);
            chk("fill_yumi", 64'(fetch_instr_yumi_o), 1);
            push_exp(39'h1000 + 39'(4*i), 32'hB0000000 + 32'(i), 1'(i & 1));
            next_cyc();
        end
        drive(1'b1, 39'h1010, 32'hB0000004, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("full_flag", 64'(full_o), 1);
        chk("full_count", 64'(count_o), 4);
        chk("full_yumi5", 64'(fetch_instr_yumi_o), 0);
        next_cyc();
        drive(1'b1, 39'h1010, 32'hB0000004, 1'b0, 1'b1);
        @(negedge clk_i);
        chk("full_deq_yumi", 64'(fetch_instr_yumi_o), 0);
        chk("full_deq_v", 64'(instr_v_o), 1);
        next_cyc();
        drive(1'b1, 39'h1010, 32'hB0000004, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("after_deq_full", 64'(full_o), 0);
        chk("after_deq_count", 64'(count_o), 3);
        chk("after_deq_yumi", 64'(fetch_instr_yumi_o), 1);
        push_exp(39'h1010, 32'hB0000004, 1'b0);
        next_cyc();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (4) next_cyc();
        @(negedge clk_i);
        chk("fill_drained", 64'(count_o), 0);
        next_cyc();

        // Wrap and ordering with ready toggling; bench models occupancy
        sent = 0;
        cyc = 0;
        model_cnt = 0;
        while (sent < 10 && cyc < 60) begin
            drive(1'b1, 39'h3000 + 39'(4*sent), 32'hA0000000 + 32'(sent), 1'(sent & 1),
                  1'(cyc & 1));
            exp_enq = (model_cnt < 4);
            exp_deq = (model_cnt > 0) && ((cyc & 1) == 1);
            @(negedge clk_i);
            chk("wrap_count", 64'(count_o), 64'(model_cnt));
            chk("wrap_yumi", 64'(fetch_instr_yumi_o), 64'(exp_enq));
            if (exp_enq) push_exp(39'h3000 + 39'(4*sent), 32'hA0000000 + 32'(sent), 1'(sent & 1));
            model_cnt = model_cnt + int'(exp_enq) - int'(exp_deq);
            next_cyc();
            if (exp_enq) sent++;
            cyc++;
        end
        chk("wrap_sent", 64'(sent), 10);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (model_cnt) next_cyc();
        @(negedge clk_i);
        chk("wrap_drained", 64'(count_o), 0);
        chk("wrap_sb_empty", 64'(sb.size()), 0);
        next_cyc();

        // Flush mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 39'h4000 + 39'(4*i), 32'hC0000000 + 32'(i), 1'b0, 1'b0);
            next_cyc();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("pre_flush_count", 64'(count_o), 3);
        next_cyc();
        flush_i = 1'b1;
        drive(1'b1, 39'h5000, 32'hDEAD0000, 1'b0, 1'b1);
        @(negedge clk_i);
        chk("flush_yumi", 64'(fetch_instr_yumi_o), 0);
        chk("flush_v", 64'(instr_v_o), 0);
        next_cyc();
        sb.delete();
        flush_i = 1'b0;
        drive(1'b1, 39'h2000, 32'h00100093, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("post_flush_count", 64'(count_o), 0);
        chk("post_flush_yumi", 64'(fetch_instr_yumi_o), 1);
        push_exp(39'h2000, 32'h00100093, 1'b1);
        next_cyc();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        @(negedge clk_i);
        chk("post_flush_v", 64'(instr_v_o), 1);
        next_cyc();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("post_flush_drained", 64'(count_o), 0);
        next_cyc();

        // Reset mid-operation
        drive(1'b1, 39'h6000, 32'hE0000000, 1'b0, 1'b0);
        next_cyc();
        drive(1'b1, 39'h6004, 32'hE0000001, 1'b1, 1'b0);
        next_cyc();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("pre_rst_count", 64'(count_o), 2);
        next_cyc();
        reset_n_i = 1'b0;
        next_cyc();
        reset_n_i = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        @(negedge clk_i);
        chk("mid_rst_count", 64'(count_o), 0);
        chk("mid_rst_v", 64'(instr_v_o), 0);
        next_cyc();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("mid_rst_stays_empty", 64'(instr_v_o), 0);
            next_cyc();
        end

        // Simultaneous enqueue/dequeue at occupancy 1
        drive(1'b1, 39'h7000, 32'hF0000000, 1'b0, 1'b0);
        push_exp(39'h7000, 32'hF0000000, 1'b0);
        next_cyc();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 39'h7004 + 39'(4*k), 32'hF0000001 + 32'(k), 1'(k & 1), 1'b1);
            @(negedge clk_i);
            chk("sim_count", 64'(count_o), 1);
            chk("sim_yumi", 64'(fetch_instr_yumi_o), 1);
            push_exp(39'h7004 + 39'(4*k), 32'hF0000001 + 32'(k), 1'(k & 1));
            next_cyc();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        next_cyc();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("sim_drained", 64'(count_o), 0);
        chk("final_sb_empty", 64'(sb.size()), 0);
        next_cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
